p_box: RTL and testbench

P_BOX -- requirements
Module: p_box

---
 rtl/p_box.sv | 51 +++++
 tb/tb_p_box.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/p_box.sv
// 48-bit fixed bit permutation with a selectable inverse.
// One registered stage: one word per cycle, no backpressure.
module p_box (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        inv,
    input  logic [47:0] data,
    output logic [47:0] permutation,
    output logic        out_valid
);

    // Source bit of each output bit, listed from index 47 down to 0
    localparam logic [5:0] S [47:0] = '{
        6'd45, 6'd42, 6'd25, 6'd22, 6'd4,  6'd2,
        6'd46, 6'd43, 6'd24, 6'd21, 6'd7,  6'd1,
        6'd44, 6'd41, 6'd23, 6'd18, 6'd15, 6'd0,
        6'd35, 6'd33, 6'd30, 6'd29, 6'd11, 6'd5,
        6'd47, 6'd37, 6'd28, 6'd17, 6'd9,  6'd3,
        6'd40, 6'd39, 6'd19, 6'd16, 6'd14, 6'd10,
        6'd38, 6'd32, 6'd26, 6'd20, 6'd13, 6'd8,
        6'd36, 6'd34, 6'd31, 6'd27, 6'd12, 6'd6
    };

    logic [47:0] fwd;
    logic [47:0] bwd;
    logic [47:0] sel;

    genvar k;
    generate
        for (k = 0; k < 48; k++) begin : g_map
            assign fwd[k]    = data[S[k]];
            assign bwd[S[k]] = data[k];
        end
    endgenerate

    assign sel = inv ? bwd : fwd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            permutation <= 48'h0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                permutation <= sel;
            end
        end
    end

endmodule

// File: tb/tb_p_box.sv
// Scoreboard bench for p_box: random and directed words,
// checked by a decoupled monitor against a table-driven model.
module tb_p_box;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        inv;
    logic [47:0] data;
    logic [47:0] permutation;
    logic        out_valid;

    p_box dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .inv         (inv),
        .data        (data),
        .permutation (permutation),
        .out_valid   (out_valid)
    );

    typedef struct packed {
        logic        v;
        logic [47:0] e;
    } item_t;

    item_t       q[$];
    logic [47:0] held;
    int          checks;
    int          errors;
    bit          mon_en;
    logic [47:0] words[$];

    int SM [47:0] = '{
        45, 42, 25, 22, 4,  2,
        46, 43, 24, 21, 7,  1,
        44, 41, 23, 18, 15, 0,
        35, 33, 30, 29, 11, 5,
        47, 37, 28, 17, 9,  3,
        40, 39, 19, 16, 14, 10,
        38, 32, 26, 20, 13, 8,
        36, 34, 31, 27, 12, 6
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] fwd_model(input logic [47:0] d);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 48; k++) r[k] = d[SM[k]];
        return r;
    endfunction

    // Inverse by searching which output position each bit came from
    function automatic logic [47:0] inv_model(input logic [47:0] d);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++)
            for (int k = 0; k < 48; k++)
                if (SM[k] == j) r[j] = d[k];
        return r;
    endfunction

    task automatic check(input string name, input logic [47:0] act,
                         input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input bit v, input bit i, input logic [47:0] d,
                         input logic [47:0] e);
        item_t it;
        @(negedge clk);
        in_valid = v;
        inv      = i;
        data     = d;
        it.v     = v;
        it.e     = e;
        q.push_back(it);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        data     = 48'(32'($urandom));
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    always begin
        item_t       it;
        logic        ev;
        logic [47:0] ep;
        @(posedge clk);
        #1;
        if (mon_en) begin
            ev = 1'b0;
            ep = held;
            if (q.size() > 0) begin
                it = q.pop_front();
                if (it.v) begin
                    ev   = 1'b1;
                    ep   = it.e;
                    held = it.e;
                end
            end
            check("out_valid", {47'h0, out_valid}, {47'h0, ev});
            check("permutation", permutation, ep);
        end
    end

    initial begin
        logic [47:0] w;
        checks   = 0;
        errors   = 0;
        held     = '0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        inv      = 1'b0;
        data     = '0;
        #12;
        check("reset_perm", permutation, 48'h0);
        check("reset_valid", {47'h0, out_valid}, 48'h0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle();

        drive(1, 0, 48'h0000_0000_0001, 48'h0000_4000_0000);
        drive(1, 0, 48'h8000_0000_0000, 48'h0000_0080_0000);
        drive(1, 0, 48'h2000_0000_0000, 48'h8000_0000_0000);
        drive(1, 0, 48'hFFFF_FFFF_FFFE, 48'hFFFF_BFFF_FFFF);
        drive(1, 1, 48'h0000_4000_0000, 48'h0000_0000_0001);
        drive(1, 0, 48'h0, 48'h0);
        drive(1, 1, 48'h0, 48'h0);
        drive(1, 0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
        drive(1, 1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);

        for (int i = 0; i < 48; i++) begin
            w = 48'h1 << i;
            drive(1, 0, w, fwd_model(w));
        end
        for (int i = 0; i < 48; i++) begin
            w = 48'h1 << i;
            drive(1, 0, ~w, ~fwd_model(w));
        end

        for (int i = 0; i < 120; i++) begin
            w = rnd48();
            words.push_back(w);
            drive(1, 0, w, fwd_model(w));
        end
        foreach (words[i]) drive(1, 1, fwd_model(words[i]), words[i]);

        for (int i = 0; i < 200; i++) begin
            w = rnd48();
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) drive(1, 1, w, inv_model(w));
                else drive(1, 0, w, fwd_model(w));
            end else begin
                drive(0, $urandom_range(0, 1) == 1, w, 48'h0);
            end
        end

        drive(1, 0, 48'h0000_0000_0001, 48'h0000_4000_0000);
        drive(1, 0, 48'h1234_5678_9ABC, fwd_model(48'h1234_5678_9ABC));
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        held     = '0;
        #1;
        check("midreset_perm", permutation, 48'h0);
        check("midreset_valid", {47'h0, out_valid}, 48'h0);
        idle();
        idle();
        rst = 1'b0;
        idle();
        w = rnd48();
        drive(1, 0, w, fwd_model(w));
        idle();
        idle();
        idle();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
